// File: rtl/debug_pkg.sv
// Shared definitions for the UART-driven debug loader.
// Command bytes and FSM state encoding.
package debug_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_HALT = 8'h48;
  localparam logic [7:0] CMD_RST  = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LCNT  = 3'd1,
    ST_LWORD = 3'd2,
    ST_WRITE = 3'd3,
    ST_RUN   = 3'd4,
    ST_STEP  = 3'd5
  } state_t;

endpackage

// File: rtl/debug_loader_if.sv
// UART-side inputs plus core and instruction-memory controls.
// master = loader side, slave = surrounding system.
interface debug_loader_if #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8,
  parameter int NB_ADDR = 8
);
  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_rx_done;
  logic               i_cpu_halt;
  logic               o_imem_we;
  logic [NB_ADDR-1:0] o_imem_addr;
  logic [NB_DATA-1:0] o_imem_data;
  logic               o_cpu_en;
  logic               o_cpu_rst;
  logic               o_busy;
  logic               o_load_done;
  logic               o_error;

  modport master (
    input  i_rx_data, i_rx_done, i_cpu_halt,
    output o_imem_we, o_imem_addr, o_imem_data,
    output o_cpu_en, o_cpu_rst, o_busy,
    output o_load_done, o_error
  );

  modport slave (
    output i_rx_data, i_rx_done, i_cpu_halt,
    input  o_imem_we, o_imem_addr, o_imem_data,
    input  o_cpu_en, o_cpu_rst, o_busy,
    input  o_load_done, o_error
  );
endinterface

// File: rtl/debug_word_packer.sv
// Packs bytes MSB-first into an instruction word.
// word_valid fires with the last byte; word is valid the next cycle.
module debug_word_packer #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NB_BYTE-1:0] i_byte,
  input  logic               i_strobe,
  input  logic               i_clear,
  output logic [NB_DATA-1:0] o_word,
  output logic               o_word_valid
);

  localparam int NBYTES = NB_DATA / NB_BYTE;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [CW-1:0]      cnt;
  logic [NB_DATA-1:0] sh;
  logic               last;

  assign last         = (cnt == CW'(NBYTES - 1));
  assign o_word_valid = i_strobe & last & ~i_clear;
  assign o_word       = sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sh  <= '0;
    end else if (i_clear) begin
      cnt <= '0;
      sh  <= '0;
    end else if (i_strobe) begin
      sh  <= NB_DATA'({sh, i_byte});
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/debug_loader.sv
// Command sequencer: loads imem words over UART and
// controls run/step/halt/reset of the core.
module debug_loader
  import debug_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8,
  parameter int NB_ADDR = 8,
  parameter int TIMEOUT = 500000
) (
  input logic            clk,
  input logic            i_rst_n,
  debug_loader_if.master bus
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t             state, state_n;
  logic               err_n, err_q;
  logic               done_n, done_q;
  logic               crst_n, crst_q;
  logic               start;
  logic [NB_ADDR-1:0] addr;
  logic [NB_BYTE-1:0] remain;
  logic [TMO_W-1:0]   tmo;
  logic               tmo_hit;
  logic [NB_DATA-1:0] word;
  logic               word_valid;
  logic               pk_strobe;
  logic [NB_BYTE-1:0] rx;
  logic               rxv;

  assign rx  = bus.i_rx_data;
  assign rxv = bus.i_rx_done;

  // WRITE also accepts bytes so a strobe there is never lost
  assign pk_strobe = rxv &
    ((state == ST_LWORD) | (state == ST_WRITE));

  debug_word_packer #(
    .NB_DATA(NB_DATA),
    .NB_BYTE(NB_BYTE)
  ) u_packer (
    .clk         (clk),
    .rst_n       (i_rst_n),
    .i_byte      (rx),
    .i_strobe    (pk_strobe),
    .i_clear     (start),
    .o_word      (word),
    .o_word_valid(word_valid)
  );

  assign tmo_hit = ~rxv & (tmo == TMO_W'(TIMEOUT));

  always_comb begin
    state_n = state;
    err_n   = 1'b0;
    done_n  = 1'b0;
    crst_n  = 1'b0;
    start   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (rxv) begin
          unique case (1'b1)
            (rx == NB_BYTE'(CMD_LOAD)): state_n = ST_LCNT;
            (rx == NB_BYTE'(CMD_RUN)):  state_n = ST_RUN;
            (rx == NB_BYTE'(CMD_STEP)): state_n = ST_STEP;
            (rx == NB_BYTE'(CMD_RST)):  crst_n  = 1'b1;
            (rx == NB_BYTE'(CMD_HALT)): ;
            default:                    err_n   = 1'b1;
          endcase
        end
      end
      ST_LCNT: begin
        if (rxv) begin
          if (rx == '0) begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            start   = 1'b1;
            state_n = ST_LWORD;
          end
        end else if (tmo_hit) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_LWORD: begin
        if (word_valid) begin
          state_n = ST_WRITE;
        end else if (tmo_hit) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (remain == NB_BYTE'(1)) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end else begin
          state_n = ST_LWORD;
        end
      end
      ST_RUN: begin
        if (bus.i_cpu_halt |
            (rxv & (rx == NB_BYTE'(CMD_HALT))))
          state_n = ST_IDLE;
      end
      ST_STEP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= ST_IDLE;
      err_q  <= 1'b0;
      done_q <= 1'b0;
      crst_q <= 1'b0;
    end else begin
      state  <= state_n;
      err_q  <= err_n;
      done_q <= done_n;
      crst_q <= crst_n;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr   <= '0;
      remain <= '0;
    end else if (start) begin
      addr   <= '0;
      remain <= rx;
    end else if (state == ST_WRITE) begin
      addr   <= addr + 1'b1;
      remain <= remain - 1'b1;
    end
  end

  // inter-byte watchdog; holds across the WRITE cycle
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo <= '0;
    end else if (state != ST_LCNT && state != ST_LWORD &&
                 state != ST_WRITE) begin
      tmo <= '0;
    end else if (rxv) begin
      tmo <= '0;
    end else if (state != ST_WRITE && !tmo_hit) begin
      tmo <= tmo + 1'b1;
    end
  end

  assign bus.o_imem_we   = (state == ST_WRITE);
  assign bus.o_imem_addr = addr;
  assign bus.o_imem_data = word;
  assign bus.o_cpu_en    = (state == ST_RUN) |
                           (state == ST_STEP);
  assign bus.o_cpu_rst   = crst_q;
  assign bus.o_busy      = (state != ST_IDLE);
  assign bus.o_load_done = done_q;
  assign bus.o_error     = err_q;

endmodule

// File: tb/tb_debug_loader.sv
// Scoreboard bench for debug_loader: imem writes are queued
// when bytes are sent and popped when o_imem_we fires.
module tb_debug_loader;

  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  debug_loader_if #(.NB_DATA(32), .NB_BYTE(8), .NB_ADDR(8)) bus ();

  debug_loader #(
    .NB_DATA(32), .NB_BYTE(8), .NB_ADDR(8), .TIMEOUT(TMO)
  ) dut (
    .clk    (clk),
    .i_rst_n(rst_n),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt = 0, done_cnt = 0, err_cnt = 0;
  int rstp_cnt = 0, en_cyc = 0, rise_cnt = 0;
  logic en_prev = 1'b0;
  logic [39:0] exp_q[$];
  logic [31:0] wq[$];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {18'd0, bus.o_imem_we, bus.o_imem_addr,
            bus.o_imem_data, bus.o_cpu_en, bus.o_cpu_rst,
            bus.o_busy, bus.o_load_done, bus.o_error};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_imem_we) begin
        logic [39:0] e;
        we_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_we", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("we_addr", bus.o_imem_addr, e[39:32]);
          check("we_data", bus.o_imem_data, e[31:0]);
        end
      end
      if (bus.o_load_done) done_cnt++;
      if (bus.o_error) err_cnt++;
      if (bus.o_cpu_rst) rstp_cnt++;
      if (bus.o_cpu_en) en_cyc++;
      if (bus.o_cpu_en && !en_prev) rise_cnt++;
      en_prev = bus.o_cpu_en;
    end else begin
      en_prev = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(posedge clk);
    #1;
    bus.i_rx_done = 1'b0;
  endtask

  // sends L, count, then all words of wq starting at address 0
  task automatic do_load();
    send_byte(8'h4C);
    idle(3);
    send_byte(8'(wq.size()));
    idle(3);
    for (int i = 0; i < wq.size(); i++) begin
      logic [31:0] w;
      w = wq[i];
      exp_q.push_back({8'(i), w});
      for (int k = 3; k >= 0; k--) begin
        send_byte(w[k*8 +: 8]);
        idle(3);
      end
    end
  endtask

  int we0, d0, e0, r0, c0, en0;

  task automatic snap();
    we0 = we_cnt; d0 = done_cnt; e0 = err_cnt;
    r0 = rise_cnt; c0 = rstp_cnt; en0 = en_cyc;
  endtask

  initial begin
    bus.i_rx_data  = '0;
    bus.i_rx_done  = 1'b0;
    bus.i_cpu_halt = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("reset_outs", outs(), 0);
    #20 rst_n = 1'b1;
    idle(2);

    // single word
    snap();
    wq = '{32'h20010014};
    do_load();
    idle(2);
    check("l1_we", we_cnt - we0, 1);
    check("l1_done", done_cnt - d0, 1);
    check("l1_busy", bus.o_busy, 0);

    // three words
    snap();
    wq = '{32'hAABBCCDD, 32'h00000000, 32'hFFFFFFFF};
    do_load();
    idle(2);
    check("l3_we", we_cnt - we0, 3);
    check("l3_done", done_cnt - d0, 1);
    check("l3_en", en_cyc - en0, 0);

    // zero-length load
    snap();
    send_byte(8'h4C);
    idle(3);
    send_byte(8'h00);
    idle(2);
    check("l0_done", done_cnt - d0, 1);
    check("l0_we", we_cnt - we0, 0);
    check("l0_busy", bus.o_busy, 0);

    // byte arriving in the WRITE cycle
    snap();
    send_byte(8'h4C);
    idle(3);
    send_byte(8'h02);
    idle(3);
    exp_q.push_back({8'd0, 32'h11223344});
    exp_q.push_back({8'd1, 32'h55667788});
    send_byte(8'h11); idle(3);
    send_byte(8'h22); idle(3);
    send_byte(8'h33); idle(3);
    @(posedge clk);
    #1;
    bus.i_rx_data = 8'h44;
    bus.i_rx_done = 1'b1;
    @(posedge clk);
    #1;
    bus.i_rx_data = 8'h55;
    @(posedge clk);
    #1;
    bus.i_rx_done = 1'b0;
    idle(3);
    send_byte(8'h66); idle(3);
    send_byte(8'h77); idle(3);
    send_byte(8'h88); idle(3);
    check("b2b_we", we_cnt - we0, 2);
    check("b2b_done", done_cnt - d0, 1);

    // run, halted by i_cpu_halt
    snap();
    send_byte(8'h52);
    check("run_en", bus.o_cpu_en, 1);
    idle(50);
    #1 bus.i_cpu_halt = 1'b1;
    @(posedge clk);
    #1 bus.i_cpu_halt = 1'b0;
    check("halt_en", bus.o_cpu_en, 0);
    check("halt_busy", bus.o_busy, 0);
    idle(2);
    check("halt_cycles", en_cyc - en0, 51);
    check("halt_rise", rise_cnt - r0, 1);

    // run, halted by H byte; stray byte ignored
    snap();
    send_byte(8'h52);
    idle(20);
    send_byte(8'h41);
    idle(20);
    send_byte(8'h48);
    check("hb_en", bus.o_cpu_en, 0);
    check("hb_busy", bus.o_busy, 0);
    idle(2);
    check("hb_err", err_cnt - e0, 0);
    check("hb_rise", rise_cnt - r0, 1);

    // halt level and H byte together
    snap();
    send_byte(8'h52);
    idle(10);
    @(posedge clk);
    #1;
    bus.i_cpu_halt = 1'b1;
    bus.i_rx_data  = 8'h48;
    bus.i_rx_done  = 1'b1;
    @(posedge clk);
    #1;
    bus.i_cpu_halt = 1'b0;
    bus.i_rx_done  = 1'b0;
    check("both_en", bus.o_cpu_en, 0);
    idle(3);
    check("both_busy", bus.o_busy, 0);
    check("both_err", err_cnt - e0, 0);

    // single step and three steps
    snap();
    send_byte(8'h53);
    idle(3);
    check("step1_cyc", en_cyc - en0, 1);
    snap();
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h53);
      idle(3);
    end
    check("step3_cyc", en_cyc - en0, 3);
    check("step3_rise", rise_cnt - r0, 3);

    // core reset command
    snap();
    send_byte(8'h5A);
    idle(2);
    check("z_rst", rstp_cnt - c0, 1);
    check("z_busy", bus.o_busy, 0);

    // bad command
    snap();
    send_byte(8'h41);
    idle(3);
    check("bad_err", err_cnt - e0, 1);
    check("bad_other", (we_cnt - we0) + (done_cnt - d0) +
          (rise_cnt - r0) + (rstp_cnt - c0), 0);

    // inter-byte timeout
    snap();
    send_byte(8'h4C);
    idle(3);
    send_byte(8'h02);
    idle(3);
    send_byte(8'hAA);
    idle(3);
    send_byte(8'hBB);
    idle(TMO - 20);
    check("tmo_early", err_cnt - e0, 0);
    idle(40);
    check("tmo_err", err_cnt - e0, 1);
    check("tmo_we", we_cnt - we0, 0);
    check("tmo_busy", bus.o_busy, 0);

    // reset in the middle of a load
    send_byte(8'h4C);
    idle(3);
    send_byte(8'h01);
    idle(3);
    send_byte(8'hCA);
    idle(3);
    send_byte(8'hFE);
    idle(2);
    #2 rst_n = 1'b0;
    #1 check("rst_outs", outs(), 0);
    #14 rst_n = 1'b1;
    idle(2);
    snap();
    wq = '{32'hDEADBEEF};
    do_load();
    idle(2);
    check("post_we", we_cnt - we0, 1);
    check("post_done", done_cnt - d0, 1);
    check("q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
